boot_loader: RTL and testbench
==============================

// Module: boot_loader
// PURPOSE
//  Post-reset sequencer. Copies the boot image from a byte-wide EEPROM into the kpu's SRAM-backed
//  tables in order: MLU slices, MLU lookahead, control microcode. Drives the kpu's shared bootstrap
//  bus (BOOTSTRAP_DATA/ADDR, per-target N_WE) and releases N_BOOTED when the copy is complete.
//  Sits directly upstream of kpu. Instantiated only in the BOOTSTRAP build.
// PARAMETERS
//  SLICE_DEPTH      131072  bytes written to the MLU slice SRAMs (ADDR 0..SLICE_DEPTH-1)
//  LOOKAHEAD_DEPTH  65536   bytes written to the MLU lookahead SRAM
//  CONTROL_DEPTH    4096    bytes written to the microcode SRAM (uses ADDR[11:0])
//  EEPROM_WAIT      3       EEPROM read wait states, >=1; data sampled on the last wait cycle
// PORTS
//  CLK                  in   1   system clock; all state changes on the rising edge
//  RST                  in   1   asynchronous, active-high reset
//  EEPROM_ADDR          out  18  linear image byte address
//  EEPROM_N_OE          out  1   EEPROM output enable; 0 only in READ
//  EEPROM_DATA          in   8   EEPROM read data
//  DATA                 out  8   bootstrap data -> kpu BOOTSTRAP_DATA
//  ADDR                 out  17  byte offset within the current target -> kpu BOOTSTRAP_ADDR
//  MLU_SLICE_N_WE       out  1   active-low write strobe, slice SRAMs
//  MLU_LOOKAHEAD_N_WE   out  1   active-low write strobe, lookahead SRAM
//  CONTROL_N_WE         out  1   active-low write strobe, microcode SRAM
//  N_BOOTED             out  1   0 = image loaded, kpu may run
//  BOOT_ERR             out  1   1 = checksum failure (tied 0 without BOOT_CHECKSUM_EN)
// BEHAVIOUR
//  - RST=1 acts immediately: state IDLE, all N_WE=1, EEPROM_N_OE=1, N_BOOTED=1, BOOT_ERR=0,
//    ADDR=0, DATA=0, EEPROM_ADDR=0, region=SLICE, wait counter=0. All outputs are registered.
//  - FSM: IDLE -> READ -> SETUP -> WRITE -> HOLD -> (READ | CHECK | DONE); FAIL; DONE.
//    IDLE : leaves on the first edge after RST falls.
//    READ : EEPROM_N_OE=0 for EEPROM_WAIT cycles; EEPROM_DATA latched into DATA on the last one.
//    SETUP: ADDR/DATA stable, all N_WE=1 (1 cycle).
//    WRITE: exactly one N_WE=0, selected by region (1 cycle). ADDR/DATA unchanged.
//    HOLD : N_WE=1, ADDR/DATA still unchanged (1 cycle). Then EEPROM_ADDR+=1, ADDR+=1.
//  - Cost: EEPROM_WAIT+3 cycles per byte. Byte k's READ starts at edge 1+k*(EEPROM_WAIT+3).
//  - Region wrap: when ADDR reaches region depth-1 in HOLD, ADDR <- 0 and region advances
//    SLICE -> LOOKAHEAD -> CONTROL. EEPROM_ADDR never resets mid-boot (linear image).
//  - After the last CONTROL HOLD: DONE (or CHECK with macro). DONE: N_BOOTED=0, EEPROM_N_OE=1,
//    all N_WE=1; sticky until RST.
//  - Reset mid-operation (incl. mid-WRITE): N_WE deasserts asynchronously; restart at byte 0.
//  - A zero-depth region is skipped. N_WE strobes are mutually exclusive; never low outside WRITE.
// CONFIGURATION
//  BOOT_CHECKSUM_EN defined: after the last CONTROL byte, one extra READ of image byte
//    S+L+C (S/L/C = SLICE/LOOKAHEAD/CONTROL_DEPTH) into the CHECK state. Running 8-bit sum
//    (mod 256) of all image bytes plus this byte: ==0 -> DONE; !=0 -> FAIL (BOOT_ERR=1,
//    N_BOOTED=1, N_WE=1, sticky until RST). The checksum byte is never written to any SRAM.
//  undefined: no extra read, no sum register, BOOT_ERR constant 0, CHECK/FAIL unreachable.
// STRUCTURE
//  Shared package boot_pkg: FSM state enum, region enum (SLICE/LOOKAHEAD/CONTROL), widths
//    BOOT_EEPROM_AW=18, BOOT_ADDR_W=17, BOOT_DATA_W=8.
//  Sub-module boot_eeprom_reader: wait-state counter, EEPROM_N_OE and data latch; pulses
//    'done' on the sample cycle. The top level holds the FSM, address counters, region select and sum.
// TESTING  (unless noted: SLICE_DEPTH=4, LOOKAHEAD_DEPTH=2, CONTROL_DEPTH=2, EEPROM_WAIT=1)
//  1 Hold RST=1 for 5 cycles -> all N_WE=1, N_BOOTED=1, EEPROM_N_OE=1, ADDR=0, DATA=0, BOOT_ERR=0.
//  2 Image byte i = i+1 -> slice writes (a,d)=(0,1)..(3,4); lookahead (0,5),(1,6); control
//    (0,7),(1,8); one N_WE low per byte, for 1 cycle; N_BOOTED falls at edge 33 and stays 0.
//  3 Assert RST during byte 5's WRITE -> MLU_LOOKAHEAD_N_WE rises asynchronously; after release,
//    EEPROM_ADDR restarts at 0 and the full sequence of test 2 repeats.
//  4 EEPROM_WAIT=3; EEPROM_DATA changes 1 cycle before the sample cycle -> the new value is
//    latched; a change on the SETUP cycle is ignored (DATA stable through HOLD).
//  5 BOOT_CHECKSUM_EN, image 1..8 + checksum byte 0xDC -> DONE, N_BOOTED=0; checksum byte
//    0xDD -> FAIL, BOOT_ERR=1, N_BOOTED=1, no further writes.
//  6 LOOKAHEAD_DEPTH=0 -> slice bytes 1..4, then control (0,5),(1,6); lookahead N_WE never low.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and widths for the post-reset boot sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package boot_pkg;

    localparam int BOOT_EEPROM_AW = 18;
    localparam int BOOT_ADDR_W    = 17;
    localparam int BOOT_DATA_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_SETUP,
        ST_WRITE,
        ST_HOLD,
        ST_CHECK,
        ST_FAIL,
        ST_DONE
    } boot_state_t;

    typedef enum logic [1:0] {
        RGN_SLICE,
        RGN_LOOKAHEAD,
        RGN_CONTROL
    } boot_region_t;

endpackage

// File: rtl/boot_eeprom_reader.sv
// EEPROM read timing: output enable, wait-state counter and read-data latch.
// Latency: EEPROM_WAIT cycles from start; data latched on the edge that ends the last wait cycle.
// Backpressure: none; 'start' must only be pulsed while idle, 'done' pulses once per read.
module boot_eeprom_reader
    import boot_pkg::*;
#(
    parameter int EEPROM_WAIT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BOOT_DATA_W-1:0] eeprom_data,
    output logic                   n_oe,
    output logic [BOOT_DATA_W-1:0] data,
    output logic                   done
);

    localparam int CW = (EEPROM_WAIT > 1) ? $clog2(EEPROM_WAIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(EEPROM_WAIT - 1);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   n_oe_q, n_oe_d;
    logic [BOOT_DATA_W-1:0] data_q, data_d;

    // The read is active while output enable is low; the last wait cycle is the sample cycle.
    assign done = !n_oe_q && (cnt_q == LAST_CNT);
    assign n_oe = n_oe_q;
    assign data = data_q;

    // Next-state: open a read on start, count wait states, sample and close on the last one.
    always_comb begin
        cnt_d  = cnt_q;
        n_oe_d = n_oe_q;
        data_d = data_q;
        if (start) begin
            cnt_d  = '0;
            n_oe_d = 1'b0;
        end else if (done) begin
            cnt_d  = '0;
            n_oe_d = 1'b1;
            data_d = eeprom_data;
        end else if (!n_oe_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            n_oe_q <= 1'b1;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            n_oe_q <= n_oe_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Post-reset sequencer copying the EEPROM boot image into the slice, lookahead and microcode SRAMs.
// Latency: EEPROM_WAIT+3 cycles per byte; N_BOOTED falls after the last byte (BOOT_CHECKSUM_EN adds a checksum read).
// Backpressure: none; the bootstrap bus is driven open-loop, all outputs registered.
module boot_loader
    import boot_pkg::*;
#(
    parameter int SLICE_DEPTH     = 131072,
    parameter int LOOKAHEAD_DEPTH = 65536,
    parameter int CONTROL_DEPTH   = 4096,
    parameter int EEPROM_WAIT     = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    output logic [BOOT_EEPROM_AW-1:0] EEPROM_ADDR,
    output logic                      EEPROM_N_OE,
    input  logic [BOOT_DATA_W-1:0]    EEPROM_DATA,
    output logic [BOOT_DATA_W-1:0]    DATA,
    output logic [BOOT_ADDR_W-1:0]    ADDR,
    output logic                      MLU_SLICE_N_WE,
    output logic                      MLU_LOOKAHEAD_N_WE,
    output logic                      CONTROL_N_WE,
    output logic                      N_BOOTED,
    output logic                      BOOT_ERR
);

    localparam bit HAS_S = (SLICE_DEPTH > 0);
    localparam bit HAS_L = (LOOKAHEAD_DEPTH > 0);
    localparam bit HAS_C = (CONTROL_DEPTH > 0);

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t END_ST = ST_CHECK;
`else
    localparam boot_state_t END_ST = ST_DONE;
`endif

    boot_state_t               state_q, state_d;
    boot_region_t              region_q, region_d;
    logic [BOOT_ADDR_W-1:0]    addr_q, addr_d;
    logic [BOOT_EEPROM_AW-1:0] eaddr_q, eaddr_d;
    logic                      slice_n_we_q, slice_n_we_d;
    logic                      look_n_we_q, look_n_we_d;
    logic                      ctrl_n_we_q, ctrl_n_we_d;
    logic                      n_booted_q, n_booted_d;
    logic                      last_in_rgn;
    logic                      rd_start, rd_done;
`ifdef BOOT_CHECKSUM_EN
    logic [BOOT_DATA_W-1:0]    sum_q, sum_d, sum_next;
    logic                      boot_err_q, boot_err_d;
`endif

    boot_eeprom_reader #(
        .EEPROM_WAIT (EEPROM_WAIT)
    ) u_reader (
        .clk         (CLK),
        .rst         (RST),
        .start       (rd_start),
        .eeprom_data (EEPROM_DATA),
        .n_oe        (EEPROM_N_OE),
        .data        (DATA),
        .done        (rd_done)
    );

    // Detect the final offset of the region currently being written.
    always_comb begin
        last_in_rgn = 1'b0;
        case (region_q)
            RGN_SLICE:     last_in_rgn = ({15'd0, addr_q} == 32'(SLICE_DEPTH - 1));
            RGN_LOOKAHEAD: last_in_rgn = ({15'd0, addr_q} == 32'(LOOKAHEAD_DEPTH - 1));
            RGN_CONTROL:   last_in_rgn = ({15'd0, addr_q} == 32'(CONTROL_DEPTH - 1));
            default:       last_in_rgn = 1'b1;
        endcase
    end

    // Sequencer next-state: per-byte READ/SETUP/WRITE/HOLD, region advance skipping empty regions.
    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        addr_d   = addr_q;
        eaddr_d  = eaddr_q;
`ifdef BOOT_CHECKSUM_EN
        sum_d    = sum_q;
        sum_next = sum_q + EEPROM_DATA;
`endif
        case (state_q)
            ST_IDLE: begin
                if (HAS_S) begin
                    region_d = RGN_SLICE;
                    state_d  = ST_READ;
                end else if (HAS_L) begin
                    region_d = RGN_LOOKAHEAD;
                    state_d  = ST_READ;
                end else if (HAS_C) begin
                    region_d = RGN_CONTROL;
                    state_d  = ST_READ;
                end else begin
                    state_d = END_ST;
                end
            end
            ST_READ: begin
                if (rd_done) begin
                    state_d = ST_SETUP;
`ifdef BOOT_CHECKSUM_EN
                    sum_d   = sum_next;
`endif
                end
            end
            ST_SETUP: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_HOLD;
            ST_HOLD: begin
                // The image is linear across regions, so the EEPROM address never wraps.
                eaddr_d = eaddr_q + 1'b1;
                if (last_in_rgn) begin
                    addr_d = '0;
                    if (region_q == RGN_SLICE && HAS_L) begin
                        region_d = RGN_LOOKAHEAD;
                        state_d  = ST_READ;
                    end else if (region_q != RGN_CONTROL && HAS_C) begin
                        region_d = RGN_CONTROL;
                        state_d  = ST_READ;
                    end else begin
                        state_d = END_ST;
                    end
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_READ;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CHECK: begin
                if (rd_done) begin
                    state_d = (sum_next == '0) ? ST_DONE : ST_FAIL;
                end
            end
`endif
            default: state_d = state_q;
        endcase
    end

    // Registered outputs derived from the next state; a new EEPROM read opens on entry to READ/CHECK.
    always_comb begin
        rd_start     = (state_d == ST_READ || state_d == ST_CHECK) &&
                       !(state_q == ST_READ || state_q == ST_CHECK);
        slice_n_we_d = !(state_d == ST_WRITE && region_q == RGN_SLICE);
        look_n_we_d  = !(state_d == ST_WRITE && region_q == RGN_LOOKAHEAD);
        ctrl_n_we_d  = !(state_d == ST_WRITE && region_q == RGN_CONTROL);
        n_booted_d   = (state_d != ST_DONE);
`ifdef BOOT_CHECKSUM_EN
        boot_err_d   = (state_d == ST_FAIL);
`endif
    end

    // FSM and datapath registers; reset deasserts every strobe immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            region_q     <= RGN_SLICE;
            addr_q       <= '0;
            eaddr_q      <= '0;
            slice_n_we_q <= 1'b1;
            look_n_we_q  <= 1'b1;
            ctrl_n_we_q  <= 1'b1;
            n_booted_q   <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= '0;
            boot_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            region_q     <= region_d;
            addr_q       <= addr_d;
            eaddr_q      <= eaddr_d;
            slice_n_we_q <= slice_n_we_d;
            look_n_we_q  <= look_n_we_d;
            ctrl_n_we_q  <= ctrl_n_we_d;
            n_booted_q   <= n_booted_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= sum_d;
            boot_err_q   <= boot_err_d;
`endif
        end
    end

    assign EEPROM_ADDR        = eaddr_q;
    assign ADDR               = addr_q;
    assign MLU_SLICE_N_WE     = slice_n_we_q;
    assign MLU_LOOKAHEAD_N_WE = look_n_we_q;
    assign CONTROL_N_WE       = ctrl_n_we_q;
    assign N_BOOTED           = n_booted_q;
`ifdef BOOT_CHECKSUM_EN
    assign BOOT_ERR           = boot_err_q;
`else
    assign BOOT_ERR           = 1'b0;
`endif

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (W=1 with 4/2/2 regions, W=3 with an empty lookahead region).
// Each write strobe is checked against an expected write list built from the image and region depths.
// BOOT_CHECKSUM_EN in the build adds checksum-pass and checksum-fail boots.
`timescale 1ns/1ps
module tb_boot_loader;

    typedef struct packed {
        logic [1:0]  tgt;
        logic [16:0] addr;
        logic [7:0]  dat;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: SLICE=4, LOOKAHEAD=2, CONTROL=2, WAIT=1
    logic        rst_a;
    logic [17:0] ea_a;
    logic        noe_a, swe_a, lwe_a, cwe_a, nb_a, err_a;
    logic [7:0]  ed_a, dat_a;
    logic [16:0] adr_a;
    logic [7:0]  mem_a [0:255];
    assign ed_a = (ea_a < 18'd256) ? mem_a[ea_a[7:0]] : 8'h00;

    boot_loader #(.SLICE_DEPTH(4), .LOOKAHEAD_DEPTH(2), .CONTROL_DEPTH(2), .EEPROM_WAIT(1)) dut_a (
        .CLK(clk), .RST(rst_a), .EEPROM_ADDR(ea_a), .EEPROM_N_OE(noe_a), .EEPROM_DATA(ed_a),
        .DATA(dat_a), .ADDR(adr_a), .MLU_SLICE_N_WE(swe_a), .MLU_LOOKAHEAD_N_WE(lwe_a),
        .CONTROL_N_WE(cwe_a), .N_BOOTED(nb_a), .BOOT_ERR(err_a)
    );

    // Instance B: SLICE=4, LOOKAHEAD=0, CONTROL=2, WAIT=3; EEPROM data valid only from one cycle before sampling
    logic        rst_b;
    logic [17:0] ea_b;
    logic        noe_b, swe_b, lwe_b, cwe_b, nb_b, err_b;
    logic [7:0]  ed_b, dat_b, raw_b;
    logic [16:0] adr_b;
    logic [7:0]  mem_b [0:255];
    int          oe_cnt_b = 0;
    always @(posedge clk) oe_cnt_b <= noe_b ? 0 : oe_cnt_b + 1;
    assign raw_b = (ea_b < 18'd256) ? mem_b[ea_b[7:0]] : 8'h00;
    assign ed_b  = (!noe_b && oe_cnt_b >= 1) ? raw_b : ~raw_b;

    boot_loader #(.SLICE_DEPTH(4), .LOOKAHEAD_DEPTH(0), .CONTROL_DEPTH(2), .EEPROM_WAIT(3)) dut_b (
        .CLK(clk), .RST(rst_b), .EEPROM_ADDR(ea_b), .EEPROM_N_OE(noe_b), .EEPROM_DATA(ed_b),
        .DATA(dat_b), .ADDR(adr_b), .MLU_SLICE_N_WE(swe_b), .MLU_LOOKAHEAD_N_WE(lwe_b),
        .CONTROL_N_WE(cwe_b), .N_BOOTED(nb_b), .BOOT_ERR(err_b)
    );

    wr_t        exp_a[$];
    wr_t        exp_b[$];
    bit         prev_low [2];
    logic [7:0] last_dat [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Image: i+1 (mode 0) or random (mode 1); checksum byte appended when the feature is built in.
    task automatic fill_image(input bit sel, input bit mode, input int n);
        logic [7:0] v, sum;
        sum = 8'h00;
        for (int i = 0; i < 256; i++) begin
            v = (mode || i >= n) ? 8'($urandom_range(0, 255)) : 8'(i + 1);
            if (i < n) sum = sum + v;
            if (sel) mem_b[i] = v; else mem_a[i] = v;
        end
`ifdef BOOT_CHECKSUM_EN
        if (sel) mem_b[n] = 8'h00 - sum; else mem_a[n] = 8'h00 - sum;
`endif
    endtask

    // Reference write list: regions in order, offsets restart per region, image consumed linearly.
    task automatic build_exp(input bit sel, input int s, input int l, input int c);
        int  k;
        int  d;
        wr_t w;
        k = 0;
        if (sel) exp_b.delete(); else exp_a.delete();
        for (int r = 0; r < 3; r++) begin
            d = (r == 0) ? s : (r == 1) ? l : c;
            for (int i = 0; i < d; i++) begin
                w.tgt  = r[1:0];
                w.addr = i[16:0];
                w.dat  = sel ? mem_b[k] : mem_a[k];
                k++;
                if (sel) exp_b.push_back(w); else exp_a.push_back(w);
            end
        end
    endtask

    task automatic mon_step(input bit sel, input logic [2:0] nwe, input logic [16:0] adr, input logic [7:0] dat);
        int  nlow;
        int  qn;
        wr_t w;
        nlow = int'(!nwe[2]) + int'(!nwe[1]) + int'(!nwe[0]);
        if (nlow != 0) begin
            chk("we_mutex", nlow, 1);
            chk("we_single_cycle", {31'd0, prev_low[sel]}, 0);
            qn = sel ? exp_b.size() : exp_a.size();
            chk("write_expected", {31'd0, qn != 0}, 1);
            if (qn != 0) begin
                w = sel ? exp_b.pop_front() : exp_a.pop_front();
                chk("write_target", (!nwe[2]) ? 0 : (!nwe[1]) ? 1 : 2, {30'd0, w.tgt});
                chk("write_addr", {15'd0, adr}, {15'd0, w.addr});
                chk("write_data", {24'd0, dat}, {24'd0, w.dat});
            end
            last_dat[sel] = dat;
        end else if (prev_low[sel]) begin
            chk("data_stable_hold", {24'd0, dat}, {24'd0, last_dat[sel]});
        end
        prev_low[sel] = (nlow != 0);
    endtask

    // Strobe monitor for both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_a) prev_low[0] = 1'b0; else mon_step(1'b0, {swe_a, lwe_a, cwe_a}, adr_a, dat_a);
        if (rst_b) prev_low[1] = 1'b0; else mon_step(1'b1, {swe_b, lwe_b, cwe_b}, adr_b, dat_b);
    end

    task automatic set_rst(input bit sel, input logic v);
        if (sel) rst_b = v; else rst_a = v;
    endtask

    // One full boot: pulse reset, then check restart address, final edge, drained write list, end state.
    task automatic run_boot(input bit sel, input int s, input int l, input int c, input int w, input bit ok);
        int   exp_edge;
        int   e;
        bit   seen;
        logic nb, err, noe;
        exp_edge = 1 + (s + l + c) * (w + 3);
`ifdef BOOT_CHECKSUM_EN
        exp_edge += w;
`endif
        @(negedge clk);
        set_rst(sel, 1'b1);
        build_exp(sel, s, l, c);
        repeat (2) @(negedge clk);
        set_rst(sel, 1'b0);
        @(posedge clk); #1;
        chk("eeprom_addr_restart", {14'd0, sel ? ea_b : ea_a}, 0);
        chk("n_oe_first_read", {31'd0, sel ? noe_b : noe_a}, 0);
        e = 1;
        nb = sel ? nb_b : nb_a;
        err = sel ? err_b : err_a;
        seen = ok ? (nb == 1'b0) : (err == 1'b1);
        while (!seen && e < exp_edge + 20) begin
            @(posedge clk); #1;
            e++;
            nb = sel ? nb_b : nb_a;
            err = sel ? err_b : err_a;
            seen = ok ? (nb == 1'b0) : (err == 1'b1);
        end
        chk(ok ? "n_booted_fall_edge" : "boot_err_rise_edge", e, exp_edge);
        chk("writes_outstanding", sel ? exp_b.size() : exp_a.size(), 0);
        repeat (6) @(posedge clk);
        #1;
        nb = sel ? nb_b : nb_a;
        err = sel ? err_b : err_a;
        noe = sel ? noe_b : noe_a;
        chk("n_booted_final", {31'd0, nb}, ok ? 0 : 1);
        chk("boot_err_final", {31'd0, err}, ok ? 0 : 1);
        chk("n_oe_final", {31'd0, noe}, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n;
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        chk("rst_n_we", {29'd0, swe_a, lwe_a, cwe_a}, 32'h7);
        chk("rst_n_booted", {31'd0, nb_a}, 1);
        chk("rst_n_oe", {31'd0, noe_a}, 1);
        chk("rst_addr", {15'd0, adr_a}, 0);
        chk("rst_data", {24'd0, dat_a}, 0);
        chk("rst_boot_err", {31'd0, err_a}, 0);
        chk("rst_eeprom_addr", {14'd0, ea_a}, 0);
        chk("rst_b_n_booted", {31'd0, nb_b}, 1);

        // Directed image i+1, then random images
        fill_image(1'b0, 1'b0, 8);
        run_boot(1'b0, 4, 2, 2, 1, 1'b1);
        for (int r = 0; r < 3; r++) begin
            fill_image(1'b0, 1'b1, 8);
            run_boot(1'b0, 4, 2, 2, 1, 1'b1);
        end

        // Reset during the first lookahead write, then a full reboot
        fill_image(1'b0, 1'b0, 8);
        @(negedge clk);
        rst_a = 1'b1;
        build_exp(1'b0, 4, 2, 2);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        n = 0;
        while (lwe_a !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("lookahead_write_reached", {31'd0, lwe_a}, 0);
        chk("lookahead_write_addr", {15'd0, adr_a}, 0);
        #2;
        rst_a = 1'b1;
        #1;
        chk("async_we_release", {31'd0, lwe_a}, 1);
        chk("async_n_oe", {31'd0, noe_a}, 1);
        chk("async_eeprom_addr", {14'd0, ea_a}, 0);
        run_boot(1'b0, 4, 2, 2, 1, 1'b1);

        // Three wait states with late-valid EEPROM data, empty lookahead region
        fill_image(1'b1, 1'b0, 6);
        run_boot(1'b1, 4, 0, 2, 3, 1'b1);
        for (int r = 0; r < 2; r++) begin
            fill_image(1'b1, 1'b1, 6);
            run_boot(1'b1, 4, 0, 2, 3, 1'b1);
        end

`ifdef BOOT_CHECKSUM_EN
        // Checksum pass (0xDC) and fail (0xDD)
        fill_image(1'b0, 1'b0, 8);
        chk("checksum_byte_model", {24'd0, mem_a[8]}, 32'hDC);
        run_boot(1'b0, 4, 2, 2, 1, 1'b1);
        mem_a[8] = 8'hDD;
        run_boot(1'b0, 4, 2, 2, 1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
